// File: rtl/pass_entry_tx.sv
`default_nettype none
// ============================================================================
// Module  : pass_entry_tx
// Brief   : Keypad passcode collector; sends a 4-digit BCD code to a lock
//           and reports the lock's response as one-cycle event pulses.
// Revision: 1.0 - initial release
// ============================================================================
module pass_entry_tx #(
  parameter int RESP_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       grant,
  input  logic       deny,
  input  logic       lock,
  output logic       enter_button,
  output logic [3:0] ip_pass,
  output logic [2:0] digit_count,
  output logic       busy,
  output logic       result_grant,
  output logic       result_deny,
  output logic       result_lock,
  output logic       result_timeout,
  output logic       entry_err
);

  localparam int c_TIMER_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(RESP_TIMEOUT - 1);

  localparam logic [3:0] c_KEY_CLEAR  = 4'd10;
  localparam logic [3:0] c_KEY_SUBMIT = 4'd11;
  localparam logic [3:0] c_KEY_BACK   = 4'd12;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    S_ENTER = 3'd1,
    S_D1    = 3'd2,
    S_D2    = 3'd3,
    S_D3    = 3'd4,
    S_D4    = 3'd5,
    WAIT    = 3'd6,
    BLOCKED = 3'd7
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_count;
  logic [2:0]             w_count_nxt;
  logic [c_TIMER_W-1:0]   r_timer;
  logic [c_TIMER_W-1:0]   w_timer_nxt;
  logic [3:0]             r_buf [4];
  logic                   w_wr_en;
  logic [3:0]             w_ip_nxt;
  logic                   w_grant_nxt;
  logic                   w_deny_nxt;
  logic                   w_lock_nxt;
  logic                   w_timeout_nxt;
  logic                   w_err_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_timer_nxt   = '0;
    w_wr_en       = 1'b0;
    w_grant_nxt   = 1'b0;
    w_deny_nxt    = 1'b0;
    w_lock_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      COLLECT: begin
        // Lockout wins over any key arriving in the same cycle.
        if (lock) begin
          w_state_nxt = BLOCKED;
          w_count_nxt = 3'd0;
          w_lock_nxt  = 1'b1;
        end else if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (r_count < 3'd4) begin
              w_wr_en     = 1'b1;
              w_count_nxt = r_count + 3'd1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else if (key_code == c_KEY_CLEAR) begin
            w_count_nxt = 3'd0;
          end else if (key_code == c_KEY_SUBMIT) begin
            if (r_count == 3'd4) w_state_nxt = S_ENTER;
            else                 w_err_nxt   = 1'b1;
          end else if (key_code == c_KEY_BACK) begin
            if (r_count != 3'd0) w_count_nxt = r_count - 3'd1;
            else                 w_err_nxt   = 1'b1;
          end
        end
      end
      S_ENTER: w_state_nxt = S_D1;
      S_D1:    w_state_nxt = S_D2;
      S_D2, S_D3, S_D4: begin
        if (deny) begin
          w_state_nxt = COLLECT;
          w_count_nxt = 3'd0;
          w_deny_nxt  = 1'b1;
        end else begin
          w_state_nxt = (r_state == S_D2) ? S_D3 :
                        (r_state == S_D3) ? S_D4 : WAIT;
        end
      end
      WAIT: begin
        // deny outranks grant, so a simultaneous grant+deny reports deny.
        if (deny) begin
          w_state_nxt = COLLECT;
          w_count_nxt = 3'd0;
          w_deny_nxt  = 1'b1;
        end else if (grant) begin
          w_state_nxt = COLLECT;
          w_count_nxt = 3'd0;
          w_grant_nxt = 1'b1;
        end else if (lock) begin
          w_state_nxt = BLOCKED;
          w_count_nxt = 3'd0;
          w_lock_nxt  = 1'b1;
        end else if (r_timer == c_TIMER_LAST) begin
          w_state_nxt   = COLLECT;
          w_count_nxt   = 3'd0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      BLOCKED: begin
        if (!lock) w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    w_ip_nxt = 4'd0;
    case (w_state_nxt)
      S_D1:    w_ip_nxt = r_buf[0];
      S_D2:    w_ip_nxt = r_buf[1];
      S_D3:    w_ip_nxt = r_buf[2];
      S_D4:    w_ip_nxt = r_buf[3];
      default: w_ip_nxt = 4'd0;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= COLLECT;
      r_count        <= 3'd0;
      r_timer        <= '0;
      for (int i = 0; i < 4; i++) r_buf[i] <= 4'd0;
      enter_button   <= 1'b0;
      ip_pass        <= 4'd0;
      busy           <= 1'b0;
      result_grant   <= 1'b0;
      result_deny    <= 1'b0;
      result_lock    <= 1'b0;
      result_timeout <= 1'b0;
      entry_err      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_count        <= w_count_nxt;
      r_timer        <= w_timer_nxt;
      if (w_wr_en) r_buf[r_count[1:0]] <= key_code;
      enter_button   <= (w_state_nxt == S_ENTER);
      ip_pass        <= w_ip_nxt;
      busy           <= (w_state_nxt != COLLECT);
      result_grant   <= w_grant_nxt;
      result_deny    <= w_deny_nxt;
      result_lock    <= w_lock_nxt;
      result_timeout <= w_timeout_nxt;
      entry_err      <= w_err_nxt;
    end
  end

  assign digit_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pass_entry_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_pass_entry_tx
// Brief   : Randomized self-checking bench for pass_entry_tx.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pass_entry_tx;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       grant = 1'b0;
  logic       deny = 1'b0;
  logic       lock = 1'b0;
  logic       enter_button;
  logic [3:0] ip_pass;
  logic [2:0] digit_count;
  logic       busy;
  logic       result_grant;
  logic       result_deny;
  logic       result_lock;
  logic       result_timeout;
  logic       entry_err;

  int total = 0;
  int bad   = 0;
  int q[$];

  pass_entry_tx #(.RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .grant(grant), .deny(deny), .lock(lock),
    .enter_button(enter_button), .ip_pass(ip_pass), .digit_count(digit_count),
    .busy(busy), .result_grant(result_grant), .result_deny(result_deny),
    .result_lock(result_lock), .result_timeout(result_timeout),
    .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int en, input int ip, input int bsy,
                            input int cnt, input int rg, input int rd, input int rl,
                            input int rt, input int er);
    check({tag, ".enter"},   32'(enter_button),   en);
    check({tag, ".ip"},      32'(ip_pass),        ip);
    check({tag, ".busy"},    32'(busy),           bsy);
    check({tag, ".count"},   32'(digit_count),    cnt);
    check({tag, ".grant"},   32'(result_grant),   rg);
    check({tag, ".deny"},    32'(result_deny),    rd);
    check({tag, ".lock"},    32'(result_lock),    rl);
    check({tag, ".timeout"}, 32'(result_timeout), rt);
    check({tag, ".err"},     32'(entry_err),      er);
  endtask

  task automatic press(input int code);
    key_valid = 1'b1;
    key_code  = code[3:0];
    tick();
    key_valid = 1'b0;
  endtask

  // Key while collecting; model buffer is a plain queue of digits.
  task automatic key_step(input int code);
    int er;
    er = 0;
    if (code <= 9) begin
      if (q.size() < 4) q.push_back(code);
      else er = 1;
    end else if (code == 10) begin
      q.delete();
    end else if (code == 11) begin
      er = 1;
    end else if (code == 12) begin
      if (q.size() > 0) void'(q.pop_back());
      else er = 1;
    end
    press(code);
    expect_out("key", 0, 0, 0, q.size(), 0, 0, 0, 0, er);
  endtask

  task automatic fill4();
    while (q.size() < 4) key_step($urandom_range(0, 9));
  endtask

  // Submit a full code and follow it: cycle t=0 is the enter strobe,
  // t=1..4 the digits, t=5..12 waiting. kind: 0 none, 1 grant, 2 deny,
  // 3 grant+deny, 4 lock; the response is raised only during cycle t_resp.
  task automatic send(input int kind, input int t_resp);
    int d[4];
    int eff, ip;
    for (int i = 0; i < 4; i++) d[i] = q[i];
    press(11);
    for (int t = 0; t <= 12; t++) begin
      ip = (t >= 1 && t <= 4) ? d[t-1] : 0;
      expect_out("tx", (t == 0) ? 1 : 0, ip, 1, 4, 0, 0, 0, 0, 0);
      key_valid = 1'($urandom_range(0, 1));
      key_code  = 4'($urandom_range(0, 15));
      if (t == t_resp) begin
        grant = (kind == 1 || kind == 3);
        deny  = (kind == 2 || kind == 3);
        lock  = (kind == 4);
      end
      eff = 0;
      if (t == t_resp) begin
        if ((kind == 2 || kind == 3) && t >= 2) eff = 1;
        if ((kind == 1 || kind == 4) && t >= 5) eff = 1;
      end
      tick();
      key_valid = 1'b0; grant = 1'b0; deny = 1'b0; lock = 1'b0;
      if (eff == 1 || t == 12) begin
        if (eff == 1 && kind == 4) begin
          expect_out("blk", 0, 0, 1, 0, 0, 0, 1, 0, 0);
          tick();
        end else if (eff == 1) begin
          expect_out("res", 0, 0, 0, 0, (kind == 1) ? 1 : 0, (kind != 1) ? 1 : 0, 0, 0, 0);
          tick();
        end else begin
          expect_out("tmo", 0, 0, 0, 0, 0, 0, 0, 1, 0);
          tick();
        end
        expect_out("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        q.delete();
        break;
      end
    end
  endtask

  task automatic lock_test();
    lock = 1'b1;
    tick();
    q.delete();
    expect_out("lk_in", 0, 0, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      press($urandom_range(1, 4));
      expect_out("lk_hold", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    end
    lock = 1'b0;
    tick();
    expect_out("lk_out", 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_mid_d3();
    int d2;
    fill4();
    d2 = q[2];
    press(11);
    tick();
    tick();
    tick();
    check("rst.d3_ip", 32'(ip_pass), d2);
    #2 rst_n = 1'b0;
    #1;
    expect_out("rst.async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    #2 rst_n = 1'b1;
    q.delete();
    key_step(7);
  endtask

  initial begin
    int c;
    tick();
    tick();
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    key_step(1); key_step(5); key_step(3); key_step(7);
    send(1, 7);
    key_step(1); key_step(2); key_step(3); key_step(4);
    send(2, 2);
    key_step(1); key_step(5); key_step(11);
    key_step(12); key_step(10); key_step(12);
    fill4();
    key_step(9);
    send(0, 0);
    fill4();
    send(2, 9);
    lock_test();
    fill4();
    send(3, 6);
    fill4();
    send(4, 10);
    reset_mid_d3();

    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 8; k++) begin
        c = $urandom_range(0, 15);
        if (c == 11 && q.size() == 4) c = 10;
        key_step(c);
      end
      if ($urandom_range(0, 5) == 0) lock_test();
      fill4();
      send($urandom_range(0, 4), $urandom_range(0, 12));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pass_entry_tx.md
PASS_ENTRY_TX -- requirements
Module: pass_entry_tx

Interface
REQ-001 SHALL have parameter RESP_TIMEOUT, default 8, giving the cycles spent in WAIT without grant/deny before giving up.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-005 SHALL have port key_code  input  4  codes: 0-9 digit, 10 clear, 11 submit, 12 backspace, 13-15 ignored.
REQ-006 SHALL have port grant  input  1  lock response: access granted.
REQ-007 SHALL have port deny  input  1  lock response: wrong code.
REQ-008 SHALL have port lock  input  1  lock response: lockout active.
REQ-009 SHALL have port enter_button  output  1  start strobe to the lock.
REQ-010 SHALL have port ip_pass  output  4  BCD digit presented to the lock.
REQ-011 SHALL have port digit_count  output  3  digits buffered, 0-4.
REQ-012 SHALL have port busy  output  1  high whenever state is not COLLECT.
REQ-013 SHALL have ports result_grant, result_deny, result_lock, result_timeout, entry_err  output  1 each  one-cycle event pulses.

Function
REQ-014 SHALL implement states COLLECT, S_ENTER, S_D1, S_D2, S_D3, S_D4, WAIT, BLOCKED.
REQ-015 COLLECT, digit key with digit_count<4: store in buf[digit_count]; digit_count+1 next cycle.
REQ-016 COLLECT, digit key with digit_count==4: buffer unchanged; entry_err pulse next cycle.
REQ-017 COLLECT, backspace: digit_count-1 if >0; if 0, entry_err pulse.
REQ-018 COLLECT, clear: digit_count=0, no error.
REQ-019 COLLECT, submit with digit_count==4: move to S_ENTER next cycle; with <4: entry_err pulse, stay, buffer kept.
REQ-020 Codes 13-15, and any key_valid outside COLLECT, SHALL be ignored silently.
REQ-021 S_ENTER: enter_button=1, ip_pass=0 for exactly one cycle; then S_D1.
REQ-022 S_D1..S_D4: ip_pass=buf[0]..buf[3], one cycle each, enter_button=0; after S_D4, WAIT.
REQ-023 ip_pass SHALL be 0 in every state other than S_D1..S_D4.
REQ-024 Outputs SHALL be registered Moore decodes of state; submit accepted in cycle N gives enter_button high in cycle N+1 and ip_pass=buf[0] in N+2.
REQ-025 deny sampled high in S_D2, S_D3, S_D4 or WAIT: abort remaining digits; result_deny pulse; digit_count=0; go to COLLECT.
REQ-026 grant sampled high in WAIT: result_grant pulse; digit_count=0; COLLECT.
REQ-027 grant and deny both high in the same cycle SHALL be treated as deny.
REQ-028 WAIT timer SHALL count cycles in WAIT; reaching RESP_TIMEOUT with no response: result_timeout pulse, digit_count=0, COLLECT.
REQ-029 lock sampled high in COLLECT or WAIT: enter BLOCKED; result_lock pulse once on entry; digit_count=0.
REQ-030 BLOCKED: all keys ignored, enter_button=0; return to COLLECT the cycle after lock is sampled low.
REQ-031 Result/error pulses SHALL be exactly one cycle and mutually exclusive.

Reset
REQ-032 rst_n low SHALL immediately force state COLLECT, digit_count=0, buffer=0, timer=0, and all outputs 0, regardless of state.
REQ-033 First key SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-034 Keys 1,5,3,7,submit; responder asserts grant in WAIT -> enter_button 1 cycle, ip_pass 1,5,3,7 on next 4 cycles, result_grant pulse, digit_count 0.
REQ-035 Keys 1,2,3,4,submit; deny asserted during S_D2 -> ip_pass 0 from next cycle, no digits 3/4 sent, result_deny pulse, busy low.
REQ-036 Keys 1,5,submit -> entry_err, no enter_button, digit_count 2; backspace -> 1; clear -> 0; backspace -> entry_err.
REQ-037 deny then lock held high 10 cycles -> result_deny, then BLOCKED with result_lock once, keys 1-4 ignored (digit_count 0); lock low -> COLLECT next cycle.
REQ-038 RESP_TIMEOUT=8, no responder -> result_timeout exactly 8 cycles after WAIT entry; with 5th digit key while full -> entry_err.
REQ-039 rst_n low mid S_D3 -> enter_button, ip_pass, busy, digit_count all 0 at once; COLLECT after release.
